dac_spi_serializer: RTL

- Consumer end of the 16-bit `word` sample interface produced by the tone/wave generators.
- Accepts one sample per valid/ready handshake and serializes its low 12 bits as a 16-bit SPI frame to a DAC121S101-style DAC (PmodDA2).
- Sits between the wave generator and the board pins; generates SYNC, SCLK and DIN from the single system clock.

---
 rtl/dac_spi_serializer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dac_spi_serializer.sv
// ---------------------------------------------------------------------------
// dac_spi_serializer
//   Accepts one 16-bit sample per valid/ready handshake and sends its low 12
//   bits as a 16-bit SPI frame (2 don't-care bits, PD1:PD0 = 00, 12 data bits)
//   to a DAC121S101-style DAC. SYNC, SCLK and DIN all come from clk.
//
//   Parameters:
//     CLK_DIV    SCLK half-period in clk cycles (>= 1)
//     GAP_SCLKS  SYNC-high gap between frames in SCLK periods (>= 1)
//
//   Ports:
//     clk           system clock, posedge
//     rst_n         asynchronous active-low reset
//     sample        sample word, bits [11:0] used
//     sample_valid  sample present
//     sample_ready  block can accept a sample (registered)
//     dac_sync      SPI frame select, active low (registered)
//     dac_sclk      SPI clock, idles high (registered)
//     dac_din       SPI data, MSB first (registered)
//     busy          high whenever the FSM is not in IDLE (registered)
//     frame_done    one-cycle pulse as SYNC rises at the end of a frame
//
//   Optional build macro DAC_DUAL_CHANNEL_EN adds:
//     sample_b      second-channel sample, latched with sample
//     dac_din_b     second-channel SPI data, shifted in lockstep with dac_din
// ---------------------------------------------------------------------------
module dac_spi_serializer #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned GAP_SCLKS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sample,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        dac_sync,
  output logic        dac_sclk,
  output logic        dac_din,
  output logic        busy,
  output logic        frame_done
`ifdef DAC_DUAL_CHANNEL_EN
  ,
  input  logic [15:0] sample_b,
  output logic        dac_din_b
`endif
);

  localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_CYCLES = 2 * CLK_DIV * GAP_SCLKS;
  localparam int unsigned GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned BIT_W      = 5;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned SHR_W      = FRAME_BITS - 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BITS_DONE = BIT_W'(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  // Holds frame bits 14..0; bit 15 goes straight to dac_din at the handshake.
  logic [SHR_W-1:0]   shreg;
`ifdef DAC_DUAL_CHANNEL_EN
  logic [SHR_W-1:0]   shreg_b;
`endif

  // Upper sample bits carry no information for a 12-bit DAC.
  logic unused_upper;
`ifdef DAC_DUAL_CHANNEL_EN
  assign unused_upper = ^{sample[15:12], sample_b[15:12]};
`else
  assign unused_upper = ^sample[15:12];
`endif

  // Frame sequencer: handshake, 16 SCLK periods of shifting, SYNC-high gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      shreg        <= '0;
      sample_ready <= 1'b0;
      dac_sync     <= 1'b1;
      dac_sclk     <= 1'b1;
      dac_din      <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
`ifdef DAC_DUAL_CHANNEL_EN
      shreg_b      <= '0;
      dac_din_b    <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          sample_ready <= 1'b1;
          if (sample_valid && sample_ready) begin
            // Frame bit 15 is a don't-care zero; bits 13:12 are PD1:PD0 = 00.
            shreg        <= {3'b000, sample[11:0]};
            dac_din      <= 1'b0;
`ifdef DAC_DUAL_CHANNEL_EN
            shreg_b      <= {3'b000, sample_b[11:0]};
            dac_din_b    <= 1'b0;
`endif
            sample_ready <= 1'b0;
            dac_sync     <= 1'b0;
            busy         <= 1'b1;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            state        <= SHIFT;
          end
        end

        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            dac_sclk <= ~dac_sclk;
            if (dac_sclk) begin
              // Falling edge: the DAC captures dac_din here.
              bit_cnt <= bit_cnt + BIT_W'(1);
            end else if (bit_cnt == BITS_DONE) begin
              // Rising edge after the 16th fall closes the frame.
              dac_sync   <= 1'b1;
              frame_done <= 1'b1;
              dac_din    <= 1'b0;
`ifdef DAC_DUAL_CHANNEL_EN
              dac_din_b  <= 1'b0;
`endif
              gap_cnt    <= '0;
              state      <= GAP;
            end else begin
              // Rising edge: present the next bit, well ahead of the next fall.
              dac_din   <= shreg[SHR_W-1];
              shreg     <= {shreg[SHR_W-2:0], 1'b0};
`ifdef DAC_DUAL_CHANNEL_EN
              dac_din_b <= shreg_b[SHR_W-1];
              shreg_b   <= {shreg_b[SHR_W-2:0], 1'b0};
`endif
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            sample_ready <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          sample_ready <= 1'b0;
          dac_sync     <= 1'b1;
          dac_sclk     <= 1'b1;
          dac_din      <= 1'b0;
          busy         <= 1'b0;
`ifdef DAC_DUAL_CHANNEL_EN
          dac_din_b    <= 1'b0;
`endif
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
